// File: rtl/alu_operand_bank_if.sv
// Operand-bank bus: sequencer strobes and switch data inward, ALU result/flags/display outward.
interface alu_operand_bank_if #(
    parameter int W = 16
);
    logic         r0;
    logic         r1;
    logic         r2;
    logic [2:0]   c_state;
    logic [W-1:0] SW;
    logic         busy;
    logic         result_valid;
    logic [W-1:0] result;
    logic [W-1:0] disp_val;
    logic [3:0]   flags;

    modport master (
        output r0, r1, r2, c_state, SW,
        input  busy, result_valid, result, disp_val, flags
    );

    modport slave (
        input  r0, r1, r2, c_state, SW,
        output busy, result_valid, result, disp_val, flags
    );
endinterface

// File: rtl/alu_operand_bank.sv
// Operand/opcode capture plus ALU: 1-edge logic/add/sub, W+1-edge shift-add MUL; starts while busy are dropped.
// Optional {N,Z,C,V} flag register under `ALU_BANK_FLAGS_EN; flags read 0 when the macro is undefined.
module alu_operand_bank #(
    parameter int W = 16
) (
    input  logic                CLK100MHZ,
    input  logic                rst,
    input  logic                CLR,
    alu_operand_bank_if.slave   bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
`ifdef ALU_BANK_FLAGS_EN
    localparam int AW = 2 * W;
`else
    localparam int AW = W;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [2:0]    r_op;
    logic [W-1:0]  r_result;
    logic          r_valid;
    logic          r_busy;
    logic          r_r2_q;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_mcand;
    logic [AW-1:0] r_acc;
    logic [W-1:0]  r_mplier;

    logic          w_start;
    logic [W-1:0]  w_alu;

    // start fires on the first edge r2 is seen high after being low
    assign w_start = bus.r2 & ~r_r2_q;

    always_comb begin
        w_alu = '0;
        case (r_op)
            3'b000:  w_alu = r_a + r_b;
            3'b001:  w_alu = r_a - r_b;
            3'b010:  w_alu = r_a & r_b;
            3'b011:  w_alu = r_a | r_b;
            3'b100:  w_alu = r_a ^ r_b;
            default: w_alu = '0;
        endcase
    end

`ifdef ALU_BANK_FLAGS_EN
    logic [3:0] r_flags;
    logic [3:0] w_alu_flags;
    logic [3:0] w_mul_flags;

    // carry is detected as wrap (sum < A); SUB carry means no borrow
    always_comb begin
        w_alu_flags    = '0;
        w_alu_flags[3] = w_alu[W-1];
        w_alu_flags[2] = (w_alu == '0);
        case (r_op)
            3'b000: begin
                w_alu_flags[1] = (w_alu < r_a);
                w_alu_flags[0] = (r_a[W-1] == r_b[W-1]) & (w_alu[W-1] != r_a[W-1]);
            end
            3'b001: begin
                w_alu_flags[1] = (r_a >= r_b);
                w_alu_flags[0] = (r_a[W-1] != r_b[W-1]) & (w_alu[W-1] != r_a[W-1]);
            end
            default: begin
                w_alu_flags[1] = 1'b0;
                w_alu_flags[0] = 1'b0;
            end
        endcase
    end

    assign w_mul_flags = {r_acc[W-1], (r_acc[W-1:0] == '0), |r_acc[AW-1:W], 1'b0};
    assign bus.flags   = r_flags;
`else
    assign bus.flags   = 4'b0000;
`endif

    always_ff @(posedge CLK100MHZ) begin
        if (rst || CLR) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_r2_q   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
`ifdef ALU_BANK_FLAGS_EN
            r_flags  <= '0;
`endif
        end else begin
            r_r2_q <= bus.r2;
            if (!bus.r0) r_a  <= bus.SW;
            if (!bus.r1) r_b  <= bus.SW;
            if (!bus.r2) r_op <= bus.SW[2:0];

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        if (r_op == 3'b101) begin
                            // snapshot operands so later captures cannot disturb the multiply
                            r_mcand  <= AW'(r_a);
                            r_mplier <= r_b;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_valid  <= 1'b0;
                            r_state  <= S_MULT;
                        end else begin
                            r_result <= w_alu;
                            r_valid  <= 1'b1;
`ifdef ALU_BANK_FLAGS_EN
                            r_flags  <= w_alu_flags;
`endif
                        end
                    end
                end
                S_MULT: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CW'(W - 1)) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_result <= r_acc[W-1:0];
                    r_valid  <= 1'b1;
                    r_busy   <= 1'b0;
`ifdef ALU_BANK_FLAGS_EN
                    r_flags  <= w_mul_flags;
`endif
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // a new operand A marks the start of a fresh computation
            if (!bus.r0) r_valid <= 1'b0;
        end
    end

    assign bus.busy         = r_busy;
    assign bus.result_valid = r_valid;
    assign bus.result       = r_result;

    always_comb begin
        bus.disp_val = '0;
        case (bus.c_state)
            3'b000, 3'b001: bus.disp_val = r_a;
            3'b010, 3'b011: bus.disp_val = r_b;
            3'b100:         bus.disp_val = {{(W-3){1'b0}}, r_op};
            3'b101:         bus.disp_val = r_valid ? r_result : '0;
            default:        bus.disp_val = '0;
        endcase
    end
endmodule

// File: tb/tb_alu_operand_bank.sv
// Bench for alu_operand_bank: directed test-plan scenarios plus random traffic against a transaction-level model.
module tb_alu_operand_bank;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_operand_bank_if #(.W(W)) bus ();
    alu_operand_bank #(.W(W)) dut (
        .CLK100MHZ (clk),
        .rst       (rst),
        .CLR       (clr),
        .bus       (bus)
    );

    // reference model state
    logic [W-1:0] m_a, m_b, m_res, m_ma, m_mb;
    logic [2:0]   m_op;
    logic         m_valid, m_r2q;
    logic [3:0]   m_flags;
    int           m_pend;

    function automatic logic [W-1:0] alu_ref(logic [2:0] op, longint unsigned a, longint unsigned b);
        case (op)
            3'd0:    return W'(a + b);
            3'd1:    return W'(a - b);
            3'd2:    return W'(a & b);
            3'd3:    return W'(a | b);
            3'd4:    return W'(a ^ b);
            3'd5:    return W'(a * b);
            default: return '0;
        endcase
    endfunction

`ifdef ALU_BANK_FLAGS_EN
    function automatic logic [3:0] flags_ref(logic [2:0] op, longint unsigned a, longint unsigned b);
        logic [W-1:0] r;
        logic c, v;
        longint sa, sb, s, lim;
        r   = alu_ref(op, a, b);
        lim = longint'(1) << (W - 1);
        sa  = a[W-1] ? longint'(a) - 2 * lim : longint'(a);
        sb  = b[W-1] ? longint'(b) - 2 * lim : longint'(b);
        c = 1'b0;
        v = 1'b0;
        if (op == 3'd0) begin
            c = ((a + b) >> W) != 0;
            s = sa + sb;
            v = (s >= lim) || (s < -lim);
        end else if (op == 3'd1) begin
            c = (a >= b);
            s = sa - sb;
            v = (s >= lim) || (s < -lim);
        end else if (op == 3'd5) begin
            c = ((a * b) >> W) != 0;
        end
        return {r[W-1], r == '0, c, v};
    endfunction
`endif

    function automatic logic [W-1:0] disp_ref(logic [2:0] cs);
        case (cs)
            3'd0, 3'd1: return m_a;
            3'd2, 3'd3: return m_b;
            3'd4:       return W'(m_op);
            3'd5:       return m_valid ? m_res : '0;
            default:    return '0;
        endcase
    endfunction

    task automatic model_edge();
        logic start;
        if (rst || clr) begin
            m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_valid = 1'b0;
            m_pend = 0; m_r2q = 1'b1; m_flags = '0;
            return;
        end
        start = bus.r2 && !m_r2q;
        if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) begin
                m_res   = alu_ref(3'd5, m_ma, m_mb);
                m_valid = 1'b1;
`ifdef ALU_BANK_FLAGS_EN
                m_flags = flags_ref(3'd5, m_ma, m_mb);
`endif
            end
        end else if (start) begin
            if (m_op == 3'd5) begin
                m_pend = W + 1;
                m_ma = m_a;
                m_mb = m_b;
                m_valid = 1'b0;
            end else begin
                m_res   = alu_ref(m_op, m_a, m_b);
                m_valid = 1'b1;
`ifdef ALU_BANK_FLAGS_EN
                m_flags = flags_ref(m_op, m_a, m_b);
`endif
            end
        end
        if (!bus.r0) m_valid = 1'b0;
        if (!bus.r0) m_a  = bus.SW;
        if (!bus.r1) m_b  = bus.SW;
        if (!bus.r2) m_op = bus.SW[2:0];
        m_r2q = bus.r2;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(logic [W-1:0] v);
        bus.r0 = 1'b0; bus.SW = v; tick(); bus.r0 = 1'b1;
    endtask

    task automatic load_b(logic [W-1:0] v);
        bus.r1 = 1'b0; bus.SW = v; tick(); bus.r1 = 1'b1;
    endtask

    // loads the opcode, then releases r2: returns just after the start edge
    task automatic run_op(logic [2:0] op);
        bus.r2 = 1'b0; bus.SW = W'(op); tick();
        bus.r2 = 1'b1; bus.SW = $urandom; tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0;
        bus.r0 = 1'b1; bus.r1 = 1'b1; bus.r2 = 1'b1; bus.c_state = 3'd0; bus.SW = '1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (bus.result !== '0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.result_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.flags !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", bus.flags); end
        checks++; if (bus.disp_val !== '0) begin errors++; $display("FAIL reset_disp_a got=%h exp=0", bus.disp_val); end
    endtask

    task automatic test_capture();
        bus.c_state = 3'd0;
        bus.r0 = 1'b0; bus.SW = 16'h1234; tick();
        bus.r0 = 1'b1; bus.SW = 16'hFFFF; tick();
        checks++; if (bus.disp_val !== 16'h1234) begin errors++; $display("FAIL capture_a got=%h exp=1234", bus.disp_val); end
        bus.c_state = 3'd2; #1;
        checks++; if (bus.disp_val !== 16'h0000) begin errors++; $display("FAIL capture_b_held got=%h exp=0000", bus.disp_val); end
    endtask

    task automatic test_add_sub();
        logic [3:0] ef;
        load_a(16'hFFFF); load_b(16'h0002); run_op(3'd0);
        checks++; if (bus.result !== 16'h0001) begin errors++; $display("FAIL add_result got=%h exp=0001", bus.result); end
        checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", bus.result_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL add_busy got=%b exp=0", bus.busy); end
`ifdef ALU_BANK_FLAGS_EN
        ef = 4'b0010;
`else
        ef = 4'b0000;
`endif
        checks++; if (bus.flags !== ef) begin errors++; $display("FAIL add_flags got=%b exp=%b", bus.flags, ef); end
        load_a(16'h0003); load_b(16'h0005); run_op(3'd1);
        checks++; if (bus.result !== 16'hFFFE) begin errors++; $display("FAIL sub_result got=%h exp=fffe", bus.result); end
`ifdef ALU_BANK_FLAGS_EN
        ef = 4'b1000;
`else
        ef = 4'b0000;
`endif
        checks++; if (bus.flags !== ef) begin errors++; $display("FAIL sub_flags got=%b exp=%b", bus.flags, ef); end
        bus.c_state = 3'd4; #1;
        checks++; if (bus.disp_val !== 16'h0001) begin errors++; $display("FAIL disp_opcode got=%h exp=0001", bus.disp_val); end
    endtask

    task automatic test_mul();
        logic [3:0] ef;
        load_a(16'h00FF); load_b(16'h0101);
        bus.c_state = 3'd5;
        run_op(3'd5);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mul_busy_start got=%b exp=1", bus.busy); end
        for (int k = 1; k <= W; k++) begin
            tick();
            checks++;
            if (bus.busy !== 1'b1 || bus.result_valid !== 1'b0 || bus.disp_val !== '0) begin
                errors++;
                $display("FAIL mul_iter%0d busy=%b valid=%b disp=%h exp busy=1 valid=0 disp=0", k, bus.busy, bus.result_valid, bus.disp_val);
            end
        end
        tick();
        checks++; if (bus.result_valid !== 1'b1) begin errors++; $display("FAIL mul_valid_edge got=%b exp=1", bus.result_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mul_busy_done got=%b exp=0", bus.busy); end
        checks++; if (bus.result !== 16'hFFFF) begin errors++; $display("FAIL mul_result got=%h exp=ffff", bus.result); end
        checks++; if (bus.disp_val !== 16'hFFFF) begin errors++; $display("FAIL mul_disp got=%h exp=ffff", bus.disp_val); end
`ifdef ALU_BANK_FLAGS_EN
        ef = 4'b1000;
`else
        ef = 4'b0000;
`endif
        checks++; if (bus.flags !== ef) begin errors++; $display("FAIL mul_flags got=%b exp=%b", bus.flags, ef); end
    endtask

    task automatic test_clr_abort();
        load_a(16'h0033); load_b(16'h0044); run_op(3'd5);
        repeat (4) tick();
        clr = 1'b1; tick(); clr = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clr_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got=%b exp=0", bus.result_valid); end
        checks++; if (bus.result !== '0) begin errors++; $display("FAIL clr_result got=%h exp=0", bus.result); end
        bus.c_state = 3'd0; #1;
        checks++; if (bus.disp_val !== '0) begin errors++; $display("FAIL clr_a got=%h exp=0", bus.disp_val); end
        bus.c_state = 3'd3; #1;
        checks++; if (bus.disp_val !== '0) begin errors++; $display("FAIL clr_b got=%h exp=0", bus.disp_val); end
    endtask

    task automatic test_restart_ignored();
        int n;
        logic [3:0] ef;
        load_a(16'h1234); load_b(16'h0011); run_op(3'd5);
        n = 0;
        repeat (3) begin tick(); n++; end
        bus.r2 = 1'b0; bus.SW = 16'h0000; tick(); n++;
        bus.r2 = 1'b1; bus.r0 = 1'b0; bus.SW = 16'hAAAA; tick(); n++;
        bus.r0 = 1'b1; bus.r1 = 1'b0; bus.SW = 16'h5555; tick(); n++;
        bus.r1 = 1'b1;
        while (bus.result_valid !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (n != W + 1) begin errors++; $display("FAIL restart_latency got=%0d exp=%0d", n, W + 1); end
        checks++; if (bus.result !== 16'h3574) begin errors++; $display("FAIL restart_result got=%h exp=3574", bus.result); end
`ifdef ALU_BANK_FLAGS_EN
        ef = 4'b0010;
`else
        ef = 4'b0000;
`endif
        checks++; if (bus.flags !== ef) begin errors++; $display("FAIL restart_flags got=%b exp=%b", bus.flags, ef); end
        repeat (2) tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL restart_no_second got=%b exp=0", bus.busy); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bus.r0 = ($urandom_range(0, 3) != 0);
            bus.r1 = ($urandom_range(0, 3) != 0);
            bus.r2 = ($urandom_range(0, 2) != 0);
            bus.SW = W'($urandom);
            bus.c_state = 3'($urandom_range(0, 7));
            clr = ($urandom_range(0, 63) == 0);
            tick();
            checks++; if (bus.result !== m_res) begin errors++; $display("FAIL rnd%0d_result got=%h exp=%h", i, bus.result, m_res); end
            checks++; if (bus.result_valid !== m_valid) begin errors++; $display("FAIL rnd%0d_valid got=%b exp=%b", i, bus.result_valid, m_valid); end
            checks++; if (bus.busy !== (m_pend != 0)) begin errors++; $display("FAIL rnd%0d_busy got=%b exp=%b", i, bus.busy, m_pend != 0); end
            checks++; if (bus.flags !== m_flags) begin errors++; $display("FAIL rnd%0d_flags got=%b exp=%b", i, bus.flags, m_flags); end
            checks++; if (bus.disp_val !== disp_ref(bus.c_state)) begin errors++; $display("FAIL rnd%0d_disp got=%h exp=%h", i, bus.disp_val, disp_ref(bus.c_state)); end
        end
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_add_sub();
        test_mul();
        test_clr_abort();
        test_restart_ignored();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
